// File: rtl/cbm2_bus_sequencer.sv
// cbm2_bus_sequencer
// Master bus-cycle sequencer for the CBM-II system bus, clocked by clk_sys.
// Each machine cycle is a video half (vicPhase=0) followed by a CPU half
// (vicPhase=1). Every half may issue one request to the external RAM
// controller on its first cycle. If that request is still outstanding when
// the half reaches its last count, the half is held until ram_ack arrives.
// The hold lasts at most MAX_STRETCH extra cycles, after which the sequencer
// advances anyway and raises the sticky stretch_err flag.
// VIC BA/AEC DMA stalls are applied to the CPU in P2 mode only.
// Optional build macro: CBM2_SEQ_STATS_EN adds the stat_stretch and stat_dma
// saturating counters.
module cbm2_bus_sequencer #(
  parameter int PHASE_CYCLES = 16,
  parameter int MAX_STRETCH  = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        model,
  input  logic        cpu_cs_ram,
  input  logic        cpu_we,
  input  logic        vic_ba,
  input  logic        vic_aec,
  input  logic        ram_ack,
  output logic        ram_req,
  output logic        ram_we,
  output logic        cpuHasBus,
  output logic        vicPhase,
  output logic        cpu_ce,
  output logic        cpu_rdy,
  output logic        vic_ce,
  output logic        stretch_err
`ifdef CBM2_SEQ_STATS_EN
  ,
  output logic [15:0] stat_stretch,
  output logic [15:0] stat_dma
`endif
);

  // PHASE_CYCLES is expected to be even and at least 4, so the B2 half
  // (PHASE_CYCLES/2) always has distinct first and last counts.
  localparam int CW = $clog2(PHASE_CYCLES);
  localparam int SW = $clog2(MAX_STRETCH + 1);
  localparam logic [CW-1:0] LAST_P2      = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] LAST_B2      = CW'(PHASE_CYCLES / 2 - 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(MAX_STRETCH - 1);

  typedef enum logic [1:0] {
    VID      = 2'd0,
    CPU      = 2'd1,
    HOLD_VID = 2'd2,
    HOLD_CPU = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          model_q;
  logic          pending;
  logic [SW-1:0] stretch_cnt;
  logic          err_q;
  logic          rdy_q;
  logic          we_q;
  logic          bus_lost_q;

  logic          in_cpu_half;
  logic          in_hold;
  logic          vid_start;
  logic          cpu_start;
  logic          model_eff;
  logic [CW-1:0] half_last;
  logic          has_bus;
  logic          req;
  logic          pend_after;
  logic          at_end;
  logic          stretch_limit;
  logic          advance;
  logic          force_adv;
  logic          lost_now;

  // Decode the current position in the machine cycle and the half-end decision.
  always_comb begin
    in_cpu_half   = (state == CPU) || (state == HOLD_CPU);
    in_hold       = (state == HOLD_VID) || (state == HOLD_CPU);
    vid_start     = (state == VID) && (cnt == '0);
    cpu_start     = (state == CPU) && (cnt == '0);
    // The model input takes effect on the video-half entry cycle itself, so
    // the first half after a model change already uses the new length.
    model_eff     = vid_start ? model : model_q;
    half_last     = model_eff ? LAST_B2 : LAST_P2;
    has_bus       = in_cpu_half && (model_q || vic_aec);
    req           = 1'b0;
    if (!reset) begin
      if (vid_start) begin
        req = !model_eff;
      end else if (cpu_start) begin
        req = cpu_cs_ram && has_bus;
      end
    end
    // An ack in the same cycle as the request completes it immediately.
    pend_after    = (pending || req) && !ram_ack;
    at_end        = !in_hold && (cnt == half_last);
    stretch_limit = in_hold && (stretch_cnt == STRETCH_LAST);
    advance       = (at_end && !pend_after) || (in_hold && (ram_ack || stretch_limit));
    force_adv     = in_hold && !ram_ack && stretch_limit;
    lost_now      = bus_lost_q || (in_cpu_half && !has_bus);
  end

  // Next-state and next-count selection for the half-cycle sequencer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (advance) begin
      state_n = in_cpu_half ? VID : CPU;
      cnt_n   = '0;
    end else if (at_end) begin
      state_n = in_cpu_half ? HOLD_CPU : HOLD_VID;
    end else if (!in_hold) begin
      cnt_n = cnt + CW'(1);
    end
  end

  // Drive the bus-control outputs; strobes are suppressed while reset is held.
  always_comb begin
    vicPhase    = in_cpu_half;
    cpuHasBus   = has_bus;
    ram_req     = req;
    ram_we      = req && cpu_start && cpu_we;
    vic_ce      = !reset && advance && !in_cpu_half;
    cpu_ce      = !reset && advance && in_cpu_half && (rdy_q || we_q) && !lost_now;
    cpu_rdy     = rdy_q;
    stretch_err = err_q;
  end

  // State register: half type and position within the half.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= VID;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Request tracking, hold timeout, sticky error and CPU-half sampled inputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      model_q     <= 1'b0;
      pending     <= 1'b0;
      stretch_cnt <= '0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      we_q        <= 1'b0;
      bus_lost_q  <= 1'b0;
    end else begin
      pending     <= pend_after && !advance;
      stretch_cnt <= (in_hold && !advance) ? stretch_cnt + SW'(1) : '0;
      if (vid_start) begin
        model_q <= model;
      end
      if (force_adv) begin
        err_q <= 1'b1;
      end
      if (cpu_start) begin
        rdy_q      <= model_q || vic_ba;
        we_q       <= cpu_we;
        bus_lost_q <= !has_bus;
      end else if (in_cpu_half && !has_bus) begin
        bus_lost_q <= 1'b1;
      end
    end
  end

`ifdef CBM2_SEQ_STATS_EN
  logic [15:0] stretch_stat_q;
  logic [15:0] dma_stat_q;

  // Saturating counters of hold cycles and of CPU halves lost to VIC DMA.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stretch_stat_q <= '0;
      dma_stat_q     <= '0;
    end else begin
      if (in_hold && (stretch_stat_q != 16'hFFFF)) begin
        stretch_stat_q <= stretch_stat_q + 16'd1;
      end
      if (advance && in_cpu_half && (!rdy_q || lost_now) && (dma_stat_q != 16'hFFFF)) begin
        dma_stat_q <= dma_stat_q + 16'd1;
      end
    end
  end

  assign stat_stretch = stretch_stat_q;
  assign stat_dma     = dma_stat_q;
`endif

endmodule

// File: tb/tb_cbm2_bus_sequencer.sv
// tb_cbm2_bus_sequencer
// Self-checking bench for cbm2_bus_sequencer. The reference model works per
// half-cycle: from the half's inputs and the chosen ack delay it derives the
// half length, whether a request is issued and where the enables pulse, then
// compares every cycle of the half against the DUT outputs.
module tb_cbm2_bus_sequencer;

  localparam int PHASE = 16;
  localparam int MAXS  = 64;

  logic clk_sys = 1'b0;
  logic reset;
  logic model;
  logic cpu_cs_ram;
  logic cpu_we;
  logic vic_ba;
  logic vic_aec;
  logic ram_ack;
  logic ram_req;
  logic ram_we;
  logic cpuHasBus;
  logic vicPhase;
  logic cpu_ce;
  logic cpu_rdy;
  logic vic_ce;
  logic stretch_err;
`ifdef CBM2_SEQ_STATS_EN
  logic [15:0] stat_stretch;
  logic [15:0] stat_dma;
`endif

  int n_checks;
  int n_fails;
  int step_no;
  bit rdy_model;
  bit err_model;
  bit aborted;

  cbm2_bus_sequencer #(
    .PHASE_CYCLES(PHASE),
    .MAX_STRETCH (MAXS)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .model      (model),
    .cpu_cs_ram (cpu_cs_ram),
    .cpu_we     (cpu_we),
    .vic_ba     (vic_ba),
    .vic_aec    (vic_aec),
    .ram_ack    (ram_ack),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .cpuHasBus  (cpuHasBus),
    .vicPhase   (vicPhase),
    .cpu_ce     (cpu_ce),
    .cpu_rdy    (cpu_rdy),
    .vic_ce     (vic_ce),
    .stretch_err(stretch_err)
`ifdef CBM2_SEQ_STATS_EN
    ,
    .stat_stretch(stat_stretch),
    .stat_dma    (stat_dma)
`endif
  );

  // Free-running system clock.
  always #5 clk_sys = ~clk_sys;

  // Safety net against a bench that stops advancing.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string where, input bit e_vp, input bit e_hb, input bit e_rq,
                           input bit e_we, input bit e_vce, input bit e_cce, input bit e_rdy,
                           input bit e_err);
    check_output({where, " vicPhase"},    vicPhase,    e_vp);
    check_output({where, " cpuHasBus"},   cpuHasBus,   e_hb);
    check_output({where, " ram_req"},     ram_req,     e_rq);
    check_output({where, " ram_we"},      ram_we,      e_we);
    check_output({where, " vic_ce"},      vic_ce,      e_vce);
    check_output({where, " cpu_ce"},      cpu_ce,      e_cce);
    check_output({where, " cpu_rdy"},     cpu_rdy,     e_rdy);
    check_output({where, " stretch_err"}, stretch_err, e_err);
  endtask

  // Drive one cycle of inputs; sampled-only-at-start inputs get junk elsewhere.
  task automatic apply_stimulus(input bit is_cpu, input int off, input bit m, input bit cs,
                                input bit we, input bit ba, input bit aec_now, input bit ack,
                                input bit scramble);
    bit junk_mode;
    bit junk_cpu;
    junk_mode  = scramble && (is_cpu || off != 0);
    junk_cpu   = scramble && !(is_cpu && off == 0);
    reset      = 1'b0;
    model      = junk_mode ? 1'($urandom) : m;
    cpu_cs_ram = junk_cpu  ? 1'($urandom) : cs;
    cpu_we     = junk_cpu  ? 1'($urandom) : we;
    vic_ba     = junk_cpu  ? 1'($urandom) : ba;
    vic_aec    = aec_now;
    ram_ack    = ack;
  endtask

  // d: ack offset from the half's first cycle (-1 = never); stray: ack offset
  // used only when the half makes no request; abort_at: assert reset there.
  task automatic run_half(input bit is_cpu, input bit m, input bit cs, input bit we,
                          input bit ba, input bit aec, input int aec_low, input int d,
                          input int stray, input int abort_at, input bit scramble);
    int    hl;
    int    len;
    bit    req;
    bit    forced;
    bit    hb;
    bit    bus_all;
    bit    aec_now;
    bit    e_rdy;
    bit    e_cce;
    string where;
    hl     = m ? PHASE / 2 : PHASE;
    hb     = is_cpu && (m || (aec_low == 0 && aec));
    req    = is_cpu ? (cs && hb) : !m;
    forced = 1'b0;
    if (!req || (d >= 0 && d < hl)) begin
      len = hl;
    end else if (d < 0 || d > hl - 1 + MAXS) begin
      len    = hl + MAXS;
      forced = 1'b1;
    end else begin
      len = d + 1;
    end
    bus_all = 1'b1;
    for (int off = 0; off < len; off++) begin
      @(posedge clk_sys);
      #1;
      if (off == abort_at) begin
        reset   = 1'b1;
        ram_ack = 1'b0;
        aborted = 1'b1;
        return;
      end
      aec_now = (is_cpu && off < aec_low) ? 1'b0 : aec;
      apply_stimulus(is_cpu, off, m, cs, we, ba, aec_now, req ? (off == d) : (off == stray),
                     scramble);
      #1;
      hb      = is_cpu && (m || aec_now);
      bus_all = bus_all && (hb || !is_cpu);
      e_rdy   = (is_cpu && off > 0) ? (m || ba) : rdy_model;
      e_cce   = is_cpu && (off == len - 1) && (m || ba || we) && bus_all;
      where   = $sformatf("step%0d %s off%0d", step_no, is_cpu ? "cpu" : "vid", off);
      check_all(where, is_cpu, hb, req && off == 0, req && off == 0 && is_cpu && we,
                !is_cpu && off == len - 1, e_cce, e_rdy, err_model);
    end
    if (is_cpu) rdy_model = m || ba;
    if (forced) err_model = 1'b1;
  endtask

  task automatic run_pair(input bit m, input bit cs, input bit we, input bit ba, input bit aec,
                          input int aec_low, input int dv, input int dc, input int sv,
                          input int sc, input int abort_c, input bit scramble);
    step_no++;
    run_half(1'b0, m, cs, we, ba, aec, 0, dv, sv, -1, scramble);
    run_half(1'b1, m, cs, we, ba, aec, aec_low, dc, sc, abort_c, scramble);
  endtask

  // One cycle with reset held and a late ack offered; everything must read 0.
  task automatic reset_cycle_check(input string where);
    @(posedge clk_sys);
    #1;
    reset   = 1'b1;
    ram_ack = 1'b1;
    #1;
    rdy_model = 1'b0;
    err_model = 1'b0;
    check_all(where, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int pick_delay(input int hl);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return -1;
    if (r < 4) return int'($urandom_range(hl, hl - 1 + MAXS));
    return int'($urandom_range(0, hl - 1));
  endfunction

  // Directed steps followed by randomized machine cycles.
  initial begin
    n_checks   = 0;
    n_fails    = 0;
    step_no    = 0;
    rdy_model  = 1'b0;
    err_model  = 1'b0;
    aborted    = 1'b0;
    reset      = 1'b1;
    model      = 1'b0;
    cpu_cs_ram = 1'b0;
    cpu_we     = 1'b0;
    vic_ba     = 1'b1;
    vic_aec    = 1'b1;
    ram_ack    = 1'b0;
    repeat (2) @(posedge clk_sys);
    reset_cycle_check("initial reset");

    $display("[TB] P2 cycles with ack one cycle after each request");
    run_pair(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1, -1, 3, -1, 1'b0);
    run_pair(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1, -1, 3, -1, 1'b0);
    run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1, -1, -1, -1, 1'b0);

    $display("[TB] B2 cycles, CPU write to RAM, stray ack in video half");
    run_pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, -1, 1, 3, -1, -1, 1'b0);
    run_pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 0, 5, -1, -1, 1'b0);

    $display("[TB] P2 stretched halves and same-cycle ack");
    run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 25, -1, -1, -1, 1'b0);
    run_pair(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 20, 0, -1, -1, -1, 1'b0);
    run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, PHASE - 1 + MAXS, -1, -1, -1, 1'b0);

    $display("[TB] ack never returns");
    run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, -1, -1, -1, -1, 1'b0);
    run_pair(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1, -1, -1, -1, 1'b0);

    $display("[TB] VIC DMA stalls");
    run_pair(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1, 1, -1, -1, -1, 1'b0);
    run_pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 1, -1, -1, -1, 1'b0);
    run_pair(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, -1, -1, -1, 1'b0);

    $display("[TB] randomized machine cycles");
    for (int i = 0; i < 40; i++) begin
      bit rm;
      int hl;
      int aecl;
      rm   = 1'($urandom);
      hl   = rm ? PHASE / 2 : PHASE;
      aecl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_pair(rm, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), aecl,
               pick_delay(hl), pick_delay(hl), int'($urandom_range(0, hl - 1)),
               int'($urandom_range(0, hl - 1)), -1, 1'b1);
    end

    $display("[TB] reset during CPU hold");
    aborted = 1'b0;
    run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, -1, -1, -1, PHASE + 4, 1'b0);
    check_output("abort reached", aborted, 1'b1);
    reset_cycle_check("reset in hold");
    run_pair(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 2, -1, -1, -1, 1'b0);
    run_pair(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1, 1, 2, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
